// File: rtl/col_en_sched_pkg.sv
// -----------------------------------------------------------------------------
// col_en_sched_pkg
// Shared definitions for the column-group enable scheduler:
//   MOTOR_COLS         - number of motor column groups on the board
//   col_sched_state_t  - scheduler FSM state encoding (IDLE, WAKE, FAULT)
// -----------------------------------------------------------------------------
package col_en_sched_pkg;

    localparam int MOTOR_COLS = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAKE  = 2'd1,
        FAULT = 2'd2
    } col_sched_state_t;

endpackage

// File: rtl/col_en_sched_if.sv
// -----------------------------------------------------------------------------
// col_en_sched_if
// Per-group request/enable bundle between the motor sequencers and the
// scheduler.
//   req          - level request per group (sequencer -> scheduler)
//   col_en       - driver sleep_n per group (scheduler -> pins)
//   grant        - PWM may be driven per group
//   busy         - any col_en high
//   timeout_flag - sticky grant-timeout per group
// Modports: master = sequencer side, slave = scheduler side.
// -----------------------------------------------------------------------------
interface col_en_sched_if
    import col_en_sched_pkg::*;
#(
    parameter int NUM_GROUPS = MOTOR_COLS
);
    logic [NUM_GROUPS-1:0] req;
    logic [NUM_GROUPS-1:0] col_en;
    logic [NUM_GROUPS-1:0] grant;
    logic [NUM_GROUPS-1:0] timeout_flag;
    logic                  busy;

    modport master (
        output req,
        input  col_en,
        input  grant,
        input  busy,
        input  timeout_flag
    );

    modport slave (
        input  req,
        output col_en,
        output grant,
        output busy,
        output timeout_flag
    );
endinterface

// File: rtl/col_en_sched_rr_arb.sv
// -----------------------------------------------------------------------------
// rr_arb
// Combinational round-robin arbiter. Searches req_i starting at index ptr_i,
// wrapping around, and returns the first set bit as a one-hot winner.
//   req_i   - request vector
//   ptr_i   - highest-priority index for this evaluation
//   gnt_o   - one-hot winner (all zero when no request)
//   valid_o - a winner exists
// -----------------------------------------------------------------------------
module rr_arb
    import col_en_sched_pkg::*;
#(
    parameter int NUM_GROUPS = MOTOR_COLS,
    parameter int PTR_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1
) (
    input  logic [NUM_GROUPS-1:0] req_i,
    input  logic [PTR_W-1:0]      ptr_i,
    output logic [NUM_GROUPS-1:0] gnt_o,
    output logic                  valid_o
);

    // Rotating priority search starting at the pointer.
    always_comb begin
        logic [PTR_W-1:0] idx;
        logic             found;
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int off = 0; off < NUM_GROUPS; off++) begin
            idx = PTR_W'((int'(ptr_i) + off) % NUM_GROUPS);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end else begin
                found = found;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/col_en_sched.sv
// -----------------------------------------------------------------------------
// col_en_sched
// Decides when each motor column group's driver is woken (col_en) and when its
// PWM requester may drive (grant). At most MAX_ACTIVE groups are awake; wake-ups
// are serialised, each taking WAKE_CYCLES before grant. A filtered over-current
// forces every group asleep until fault_clear arrives with the fault gone.
//
// Ports:
//   clkin         - block clock
//   rst_n         - asynchronous active-low reset
//   bus (slave)   - req in; col_en, grant, busy, timeout_flag out
//   current_fault - raw over-current, synchronous to clkin
//   fault_clear   - one-cycle pulse clearing the latched fault
//   fault_latched - trip occurred and not yet cleared
//
// Optional feature macro: COL_SCHED_TIMEOUT_EN
//   When defined, each grant is limited to MAX_GRANT_CYCLES; an expired group
//   is dropped, flagged (sticky) and locked out until its req is seen low.
//   When undefined, grants are unlimited and timeout_flag is 0.
// -----------------------------------------------------------------------------
module col_en_sched
    import col_en_sched_pkg::*;
#(
    parameter int NUM_GROUPS       = MOTOR_COLS,
    parameter int MAX_ACTIVE       = 2,
    parameter int WAKE_CYCLES      = 16,
    parameter int FAULT_FILTER     = 4,
    parameter int MAX_GRANT_CYCLES = 65535
) (
    input  logic                 clkin,
    input  logic                 rst_n,
    col_en_sched_if.slave        bus,
    input  logic                 current_fault,
    input  logic                 fault_clear,
    output logic                 fault_latched
);

    localparam int PTR_W  = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam int CNT_W  = $clog2(NUM_GROUPS + 1);
    localparam int WAKE_W = $clog2(WAKE_CYCLES + 1);
    localparam int FILT_W = $clog2(FAULT_FILTER + 1);

    col_sched_state_t        state_q, state_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic [WAKE_W-1:0]       wake_cnt_q, wake_cnt_d;
    logic [NUM_GROUPS-1:0]   wake_grp_q, wake_grp_d;
    logic [NUM_GROUPS-1:0]   col_en_q, col_en_d;
    logic [NUM_GROUPS-1:0]   grant_q, grant_d;
    logic [FILT_W-1:0]       filt_q, filt_d;
    logic                    fault_latched_q, fault_latched_d;
    logic                    busy_q;

    logic [NUM_GROUPS-1:0]   req_s;
    logic [NUM_GROUPS-1:0]   rel_s;
    logic [NUM_GROUPS-1:0]   kept_s;
    logic [NUM_GROUPS-1:0]   elig_s;
    logic [NUM_GROUPS-1:0]   win_s;
    logic                    win_valid_s;
    logic [PTR_W-1:0]        win_idx_s;
    logic [CNT_W-1:0]        active_cnt_s;
    logic                    trip_s;
    logic [NUM_GROUPS-1:0]   to_drop_s;
    logic [NUM_GROUPS-1:0]   blocked_s;
    logic [NUM_GROUPS-1:0]   timeout_flag_s;

    assign req_s = bus.req;

    // Releases (req dropped or grant expired) free their slots before
    // arbitration, so a slot vacated this cycle can be reused immediately.
    always_comb begin
        rel_s        = col_en_q & (~req_s | to_drop_s);
        kept_s       = col_en_q & ~rel_s;
        elig_s       = req_s & ~col_en_q & ~blocked_s;
        active_cnt_s = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            active_cnt_s = active_cnt_s + CNT_W'(kept_s[g]);
        end
    end

    rr_arb #(
        .NUM_GROUPS (NUM_GROUPS),
        .PTR_W      (PTR_W)
    ) u_rr_arb (
        .req_i   (elig_s),
        .ptr_i   (ptr_q),
        .gnt_o   (win_s),
        .valid_o (win_valid_s)
    );

    // One-hot winner to index, for the pointer update.
    always_comb begin
        win_idx_s = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            if (win_s[g]) begin
                win_idx_s = PTR_W'(g);
            end else begin
                win_idx_s = win_idx_s;
            end
        end
    end

    // Over-current filter: saturating run-length of consecutive fault cycles.
    // The trip fires on the edge that closes the FAULT_FILTER-th such cycle.
    always_comb begin
        if (current_fault) begin
            if (filt_q == FILT_W'(FAULT_FILTER)) begin
                filt_d = filt_q;
            end else begin
                filt_d = filt_q + FILT_W'(1);
            end
        end else begin
            filt_d = '0;
        end
        trip_s = current_fault && (filt_q >= FILT_W'(FAULT_FILTER - 1));
    end

    // Scheduler next-state: arbitration in IDLE, wake timing in WAKE, forced
    // sleep in FAULT. A trip overrides everything, including wake completion.
    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        wake_cnt_d      = wake_cnt_q;
        wake_grp_d      = wake_grp_q;
        col_en_d        = col_en_q & ~rel_s;
        grant_d         = grant_q & ~rel_s;
        fault_latched_d = fault_latched_q;

        case (state_q)
            IDLE: begin
                if (win_valid_s && (int'(active_cnt_s) < MAX_ACTIVE)) begin
                    col_en_d   = col_en_d | win_s;
                    wake_grp_d = win_s;
                    wake_cnt_d = '0;
                    state_d    = WAKE;
                    if (win_idx_s == PTR_W'(NUM_GROUPS - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = win_idx_s + PTR_W'(1);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAKE: begin
                if ((wake_grp_q & rel_s) != '0) begin
                    // Waking group abandoned its request.
                    state_d    = IDLE;
                    wake_cnt_d = '0;
                    wake_grp_d = '0;
                end else if (wake_cnt_q == WAKE_W'(WAKE_CYCLES - 1)) begin
                    grant_d    = grant_d | wake_grp_q;
                    state_d    = IDLE;
                    wake_cnt_d = '0;
                    wake_grp_d = '0;
                end else begin
                    wake_cnt_d = wake_cnt_q + WAKE_W'(1);
                end
            end
            FAULT: begin
                col_en_d = '0;
                grant_d  = '0;
                if (fault_clear && !current_fault) begin
                    state_d         = IDLE;
                    fault_latched_d = 1'b0;
                end else begin
                    state_d = FAULT;
                end
            end
            default: begin
                state_d    = IDLE;
                col_en_d   = '0;
                grant_d    = '0;
                wake_cnt_d = '0;
                wake_grp_d = '0;
            end
        endcase

        if (trip_s) begin
            state_d         = FAULT;
            col_en_d        = '0;
            grant_d         = '0;
            wake_cnt_d      = '0;
            wake_grp_d      = '0;
            ptr_d           = ptr_q;
            fault_latched_d = 1'b1;
        end else begin
            fault_latched_d = fault_latched_d;
        end
    end

    // Scheduler state and output registers.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            ptr_q           <= '0;
            wake_cnt_q      <= '0;
            wake_grp_q      <= '0;
            col_en_q        <= '0;
            grant_q         <= '0;
            filt_q          <= '0;
            fault_latched_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            wake_cnt_q      <= wake_cnt_d;
            wake_grp_q      <= wake_grp_d;
            col_en_q        <= col_en_d;
            grant_q         <= grant_d;
            filt_q          <= filt_d;
            fault_latched_q <= fault_latched_d;
            busy_q          <= |col_en_d;
        end
    end

`ifdef COL_SCHED_TIMEOUT_EN
    localparam int GNT_W = $clog2(MAX_GRANT_CYCLES + 1);

    logic [GNT_W-1:0]      gcnt_q [NUM_GROUPS];
    logic [GNT_W-1:0]      gcnt_d [NUM_GROUPS];
    logic [NUM_GROUPS-1:0] blocked_q, blocked_d;
    logic [NUM_GROUPS-1:0] timeout_flag_q, timeout_flag_d;

    // Grant expiry: counter holds the number of edges grant has been high.
    always_comb begin
        to_drop_s = '0;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            if (grant_q[g] && (gcnt_q[g] == GNT_W'(MAX_GRANT_CYCLES - 1))) begin
                to_drop_s[g] = 1'b1;
            end else begin
                to_drop_s[g] = 1'b0;
            end
        end
    end

    // Grant counters, lockout until req seen low, sticky timeout flags.
    always_comb begin
        for (int g = 0; g < NUM_GROUPS; g++) begin
            if (grant_d[g] && grant_q[g]) begin
                gcnt_d[g] = gcnt_q[g] + GNT_W'(1);
            end else begin
                gcnt_d[g] = '0;
            end
        end
        blocked_d      = to_drop_s | (blocked_q & req_s);
        timeout_flag_d = (fault_clear ? '0 : timeout_flag_q) | to_drop_s;
    end

    // Timeout state registers.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            for (int g = 0; g < NUM_GROUPS; g++) begin
                gcnt_q[g] <= '0;
            end
            blocked_q      <= '0;
            timeout_flag_q <= '0;
        end else begin
            for (int g = 0; g < NUM_GROUPS; g++) begin
                gcnt_q[g] <= gcnt_d[g];
            end
            blocked_q      <= blocked_d;
            timeout_flag_q <= timeout_flag_d;
        end
    end

    assign blocked_s      = blocked_q;
    assign timeout_flag_s = timeout_flag_q;
`else
    assign to_drop_s      = '0;
    assign blocked_s      = '0;
    assign timeout_flag_s = '0;
`endif

    assign bus.col_en       = col_en_q;
    assign bus.grant        = grant_q;
    assign bus.busy         = busy_q;
    assign bus.timeout_flag = timeout_flag_s;
    assign fault_latched    = fault_latched_q;

endmodule

// File: tb/tb_col_en_sched.sv
// -----------------------------------------------------------------------------
// tb_col_en_sched
// Directed, table-driven bench for col_en_sched (NUM_GROUPS=4, MAX_ACTIVE=2,
// WAKE_CYCLES=16, FAULT_FILTER=4, MAX_GRANT_CYCLES=100). Each table row sets
// the inputs, advances a number of clock edges and compares the outputs with
// hand-computed values. Reset-in-flight, short req pulses and the grant
// timeout are covered by explicit sequences.
// -----------------------------------------------------------------------------
module tb_col_en_sched;
    import col_en_sched_pkg::*;

    logic clkin = 1'b0;
    logic rst_n;
    logic current_fault;
    logic fault_clear;
    logic fault_latched;

    int n_vec  = 0;
    int n_miss = 0;

    col_en_sched_if #(.NUM_GROUPS(4)) bus ();

    col_en_sched #(
        .NUM_GROUPS       (4),
        .MAX_ACTIVE       (2),
        .WAKE_CYCLES      (16),
        .FAULT_FILTER     (4),
        .MAX_GRANT_CYCLES (100)
    ) dut (
        .clkin         (clkin),
        .rst_n         (rst_n),
        .bus           (bus.slave),
        .current_fault (current_fault),
        .fault_clear   (fault_clear),
        .fault_latched (fault_latched)
    );

    always #5 clkin = ~clkin;

    typedef struct {
        bit         rst;
        logic [3:0] req;
        logic       cf;
        logic       fc;
        int         n;
        logic [3:0] exp_col;
        logic [3:0] exp_gnt;
        logic       exp_fl;
        logic       exp_busy;
    } vec_t;

    vec_t tbl [25];

    task automatic chk(input string nm, input int idx, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s #%0d: got %b expected %b at %0t", nm, idx, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clkin);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.req       = 4'b0000;
        current_fault = 1'b0;
        fault_clear   = 1'b0;
        repeat (2) @(posedge clkin);
        @(negedge clkin);
        rst_n = 1'b1;
    endtask

    task automatic chk_all(input string nm, input int idx, input logic [3:0] col, input logic [3:0] gnt,
                           input logic fl, input logic busy);
        chk({nm, "_col_en"}, idx, bus.col_en, col);
        chk({nm, "_grant"}, idx, bus.grant, gnt);
        chk({nm, "_fault_latched"}, idx, {3'b000, fault_latched}, {3'b000, fl});
        chk({nm, "_busy"}, idx, {3'b000, bus.busy}, {3'b000, busy});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //           rst   req      cf    fc    n   col      gnt      fl    busy
        // single request: col_en 1 edge after req, grant 16 edges later
        tbl[0]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 2,  4'b0000, 4'b0000, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 4'b0001, 1'b0, 1'b0, 1,  4'b0001, 4'b0000, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 4'b0001, 1'b0, 1'b0, 15, 4'b0001, 4'b0000, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 4'b0001, 1'b0, 1'b0, 1,  4'b0001, 4'b0001, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 1,  4'b0000, 4'b0000, 1'b0, 1'b0};
        // contention with MAX_ACTIVE=2, then round-robin on freed slots
        tbl[5]  = '{1'b1, 4'b1111, 1'b0, 1'b0, 1,  4'b0001, 4'b0000, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 4'b1111, 1'b0, 1'b0, 16, 4'b0001, 4'b0001, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 4'b1111, 1'b0, 1'b0, 1,  4'b0011, 4'b0001, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 4'b1111, 1'b0, 1'b0, 16, 4'b0011, 4'b0011, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 4'b1111, 1'b0, 1'b0, 5,  4'b0011, 4'b0011, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 4'b1110, 1'b0, 1'b0, 1,  4'b0110, 4'b0010, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 4'b1111, 1'b0, 1'b0, 16, 4'b0110, 4'b0110, 1'b0, 1'b1};
        tbl[12] = '{1'b0, 4'b1101, 1'b0, 1'b0, 1,  4'b1100, 4'b0100, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 4'b1101, 1'b0, 1'b0, 16, 4'b1100, 4'b1100, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 4'b1001, 1'b0, 1'b0, 1,  4'b1001, 4'b1000, 1'b0, 1'b1};
        // fault filter: 3 high cycles do not trip, 4th trips over wake completion
        tbl[15] = '{1'b0, 4'b1001, 1'b0, 1'b0, 8,  4'b1001, 4'b1000, 1'b0, 1'b1};
        tbl[16] = '{1'b0, 4'b1001, 1'b1, 1'b0, 3,  4'b1001, 4'b1000, 1'b0, 1'b1};
        tbl[17] = '{1'b0, 4'b1001, 1'b0, 1'b0, 1,  4'b1001, 4'b1000, 1'b0, 1'b1};
        tbl[18] = '{1'b0, 4'b1001, 1'b1, 1'b0, 3,  4'b1001, 4'b1000, 1'b0, 1'b1};
        tbl[19] = '{1'b0, 4'b1001, 1'b1, 1'b0, 1,  4'b0000, 4'b0000, 1'b1, 1'b0};
        tbl[20] = '{1'b0, 4'b1001, 1'b1, 1'b1, 1,  4'b0000, 4'b0000, 1'b1, 1'b0};
        tbl[21] = '{1'b0, 4'b1001, 1'b0, 1'b0, 3,  4'b0000, 4'b0000, 1'b1, 1'b0};
        tbl[22] = '{1'b0, 4'b1001, 1'b0, 1'b1, 1,  4'b0000, 4'b0000, 1'b0, 1'b0};
        tbl[23] = '{1'b0, 4'b1001, 1'b0, 1'b0, 1,  4'b1000, 4'b0000, 1'b0, 1'b1};
        tbl[24] = '{1'b0, 4'b1001, 1'b0, 1'b0, 17, 4'b1001, 4'b1000, 1'b0, 1'b1};

        rst_n         = 1'b0;
        bus.req       = 4'b0000;
        current_fault = 1'b0;
        fault_clear   = 1'b0;
        #1;
        chk_all("reset", 0, 4'b0000, 4'b0000, 1'b0, 1'b0);
        chk("reset_timeout_flag", 0, bus.timeout_flag, 4'b0000);

        for (int i = 0; i < 25; i++) begin
            if (tbl[i].rst) begin
                do_reset();
            end
            bus.req       = tbl[i].req;
            current_fault = tbl[i].cf;
            fault_clear   = tbl[i].fc;
            step(tbl[i].n);
            chk_all("tbl", i, tbl[i].exp_col, tbl[i].exp_gnt, tbl[i].exp_fl, tbl[i].exp_busy);
            chk("tbl_timeout_flag", i, bus.timeout_flag, 4'b0000);
        end

        // Reset mid-wake: clears without a clock; the pointer restarts at 0.
        do_reset();
        bus.req = 4'b0101;
        step(1);
        chk("rstwake_col_en", 0, bus.col_en, 4'b0001);
        step(8);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("rstwake_async", 1, 4'b0000, 4'b0000, 1'b0, 1'b0);
        @(negedge clkin);
        rst_n = 1'b1;
        step(1);
        chk("rstwake_fresh_col_en", 2, bus.col_en, 4'b0001);
        step(16);
        chk("rstwake_fresh_grant", 3, bus.grant, 4'b0001);
        step(1);
        chk("rstwake_second_col_en", 4, bus.col_en, 4'b0101);

        // Reset mid-fault clears the latched fault asynchronously.
        current_fault = 1'b1;
        step(4);
        chk("rstfault_latched", 0, {3'b000, fault_latched}, 4'b0001);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstfault_cleared", 1, {3'b000, fault_latched}, 4'b0000);
        current_fault = 1'b0;
        @(negedge clkin);
        rst_n = 1'b1;

        // A one-cycle req pulse during another group's wake is not remembered.
        do_reset();
        bus.req = 4'b0001;
        step(1);
        bus.req = 4'b0011;
        step(1);
        bus.req = 4'b0001;
        step(15);
        chk("pulse_grant", 0, bus.grant, 4'b0001);
        step(3);
        chk("pulse_col_en", 1, bus.col_en, 4'b0001);

`ifdef COL_SCHED_TIMEOUT_EN
        // Grant limited to 100 cycles; lockout until req toggles low.
        do_reset();
        bus.req = 4'b1000;
        step(1);
        chk("to_col_en", 0, bus.col_en, 4'b1000);
        step(16);
        chk("to_grant_rise", 1, bus.grant, 4'b1000);
        step(99);
        chk("to_grant_held", 2, bus.grant, 4'b1000);
        chk("to_flag_clear", 3, bus.timeout_flag, 4'b0000);
        step(1);
        chk("to_grant_drop", 4, bus.grant, 4'b0000);
        chk("to_col_en_drop", 5, bus.col_en, 4'b0000);
        chk("to_flag_set", 6, bus.timeout_flag, 4'b1000);
        step(5);
        chk("to_locked", 7, bus.col_en, 4'b0000);
        bus.req = 4'b0000;
        step(1);
        bus.req = 4'b1000;
        step(1);
        chk("to_rewake", 8, bus.col_en, 4'b1000);
        chk("to_flag_sticky", 9, bus.timeout_flag, 4'b1000);
        fault_clear = 1'b1;
        step(1);
        fault_clear = 1'b0;
        chk("to_flag_cleared", 10, bus.timeout_flag, 4'b0000);
`else
        // Without the timeout feature a grant is held indefinitely.
        do_reset();
        bus.req = 4'b1000;
        step(17);
        chk("nto_grant_rise", 0, bus.grant, 4'b1000);
        step(120);
        chk("nto_grant_held", 1, bus.grant, 4'b1000);
        chk("nto_flag_zero", 2, bus.timeout_flag, 4'b0000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
